// File: rtl/regbus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : regbus_arbiter
// Purpose  : Round-robin two-master arbiter/sequencer for the 8-bit register
//            bus (IDLE -> SETUP -> ACCESS x N -> DONE), registered outputs.
// Revision : 1.0
// ============================================================================
module regbus_arbiter #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_m0_req,
    input  logic       i_m0_we,
    input  logic [6:0] i_m0_addr,
    input  logic [7:0] i_m0_wdata,
    output logic       o_m0_ack,
    output logic [7:0] o_m0_rdata,
    input  logic       i_m1_req,
    input  logic       i_m1_we,
    input  logic [6:0] i_m1_addr,
    input  logic [7:0] i_m1_wdata,
    output logic       o_m1_ack,
    output logic [7:0] o_m1_rdata,
    output logic [4:0] o_slave_addr,
    output logic       o_wr_req,
    output logic [7:0] o_data_wr,
    output logic       o_slave0_sel,
    output logic       o_slave1_sel,
    output logic       o_slave2_sel,
    output logic       o_slave3_sel,
    input  logic [7:0] i_slave0_rdata,
    input  logic [7:0] i_slave1_rdata,
    input  logic [7:0] i_slave2_rdata,
    input  logic [7:0] i_slave3_rdata,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] c_CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t      state_q;
    logic        last_q;        // 1: master 1 was granted last
    logic        gnt_q;         // 1: master 1 owns the current transfer
    logic        we_q;
    logic [6:0]  addr_q;
    logic [3:0]  cnt_q;
    logic [4:0]  slave_addr_q;
    logic [7:0]  data_wr_q;
    logic        wr_req_q;
    logic [3:0]  sel_q;
    logic        m0_ack_q;
    logic        m1_ack_q;
    logic [7:0]  m0_rdata_q;
    logic [7:0]  m1_rdata_q;
    logic        busy_q;

    logic        w_gnt_m1;
    logic        w_we;
    logic [6:0]  w_addr;
    logic [7:0]  w_wdata;
    logic [3:0]  w_sel;
    logic [7:0]  w_slave_rdata;

    // Master 1 wins only if alone, or on contention when master 0 went last.
    assign w_gnt_m1 = i_m1_req & (~i_m0_req | ~last_q);
    assign w_we     = w_gnt_m1 ? i_m1_we    : i_m0_we;
    assign w_addr   = w_gnt_m1 ? i_m1_addr  : i_m0_addr;
    assign w_wdata  = w_gnt_m1 ? i_m1_wdata : i_m0_wdata;
    assign w_sel    = 4'b0001 << w_addr[6:5];

    always_comb begin
        w_slave_rdata = i_slave0_rdata;
        case (addr_q[6:5])
            2'd0:    w_slave_rdata = i_slave0_rdata;
            2'd1:    w_slave_rdata = i_slave1_rdata;
            2'd2:    w_slave_rdata = i_slave2_rdata;
            default: w_slave_rdata = i_slave3_rdata;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= S_IDLE;
            last_q       <= 1'b1;
            gnt_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            cnt_q        <= '0;
            slave_addr_q <= '0;
            data_wr_q    <= '0;
            wr_req_q     <= 1'b0;
            sel_q        <= '0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_m0_req || i_m1_req) begin
                        gnt_q        <= w_gnt_m1;
                        we_q         <= w_we;
                        addr_q       <= w_addr;
                        slave_addr_q <= w_addr[4:0];
                        data_wr_q    <= w_wdata;
                        sel_q        <= w_sel;
                        busy_q       <= 1'b1;
                        state_q      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    wr_req_q <= we_q;
                    cnt_q    <= c_CNT_LOAD;
                    state_q  <= S_ACCESS;
                end
                S_ACCESS: begin
                    wr_req_q <= 1'b0;
                    if (cnt_q == 4'd0) begin
                        // Read data is captured for writes as well.
                        if (gnt_q) begin
                            m1_rdata_q <= w_slave_rdata;
                            m1_ack_q   <= 1'b1;
                        end else begin
                            m0_rdata_q <= w_slave_rdata;
                            m0_ack_q   <= 1'b1;
                        end
                        sel_q        <= '0;
                        slave_addr_q <= '0;
                        data_wr_q    <= '0;
                        state_q      <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    last_q  <= gnt_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_m0_ack     = m0_ack_q;
    assign o_m1_ack     = m1_ack_q;
    assign o_m0_rdata   = m0_rdata_q;
    assign o_m1_rdata   = m1_rdata_q;
    assign o_slave_addr = slave_addr_q;
    assign o_wr_req     = wr_req_q;
    assign o_data_wr    = data_wr_q;
    assign o_slave0_sel = sel_q[0];
    assign o_slave1_sel = sel_q[1];
    assign o_slave2_sel = sel_q[2];
    assign o_slave3_sel = sel_q[3];
    assign o_busy       = busy_q;

endmodule
`default_nettype wire

// File: doc/regbus_arbiter.md
# regbus_arbiter

Two-master arbiter and sequencer for the shared 8-bit register bus that fans out to the four register slaves. It sits between the SPI-side register master and the internal capture sequencer, grants the bus to one of them per access (round-robin), and drives the shared address, write-data, write-strobe and slave-select lines in a fixed SETUP/ACCESS/DONE sequence. It returns read data and a one-cycle acknowledge to the granted master.

## Interface

Parameters:
- ACCESS_CYCLES, default 2: number of ACCESS-state cycles per transfer. Legal range is 1..15.

Ports:
- i_clk  in  1  system clock; all logic is on the rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_m0_req  in  1  master 0 (SPI side) request, level
- i_m0_we  in  1  master 0: 1 = write, 0 = read
- i_m0_addr  in  7  master 0 address; [6:5] selects the slave, [4:0] is the register
- i_m0_wdata  in  8  master 0 write data
- o_m0_ack  out  1  master 0 transfer complete, one-cycle pulse
- o_m0_rdata  out  8  master 0 read data, valid while o_m0_ack is high and held afterwards
- i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata, o_m1_ack, o_m1_rdata: same as master 0, for master 1 (capture sequencer)
- o_slave_addr  out  5  shared register address
- o_wr_req  out  1  shared write strobe
- o_data_wr  out  8  shared write data
- o_slave0_sel .. o_slave3_sel  out  1 each  slave selects, one-hot or all zero
- i_slave0_rdata .. i_slave3_rdata  in  8 each  slave read data
- o_busy  out  1  high in every state except IDLE

## Operation

States are IDLE, SETUP, ACCESS and DONE.

- **IDLE**
  - Sample both requests.
  - None asserted: stay in IDLE.
  - One asserted: grant it.
  - Both asserted: grant the master NOT granted last (round-robin).
  - On grant: latch the master's we, addr and wdata into internal registers, then go to SETUP.
- **SETUP** (1 cycle)
  - Drive o_slave_addr = addr[4:0] and o_data_wr = wdata.
  - Assert the select for addr[6:5]: 00 gives sel0, 01 sel1, 10 sel2, 11 sel3.
  - o_wr_req = 0.
  - Go to ACCESS and load the wait counter with ACCESS_CYCLES-1.
- **ACCESS** (ACCESS_CYCLES cycles)
  - Address, data and select are held.
  - o_wr_req = 1 in the first ACCESS cycle only, and only if we = 1.
  - On the last ACCESS cycle (counter = 0), capture the selected slave's rdata into the granted master's rdata register. This happens for writes too.
  - Then go to DONE.
- **DONE** (1 cycle)
  - Selects, o_wr_req, o_slave_addr and o_data_wr all return to 0.
  - The granted master's ack = 1.
  - Update last-granted, then go to IDLE.

Rules:
- The requester holds req, we, addr and wdata stable from req assertion until ack. It drops req on the clock edge at which it samples ack = 1.
- A request still high in the IDLE cycle after DONE is treated as a new request.
- The latched transfer fields are immune to input changes after the grant.
- The non-granted master's request waits. It is never dropped, and its ack stays 0.
- Requests are never granted outside IDLE.
- Only one ack is high in any cycle.
- o_mX_rdata of the non-granted master is unchanged.

## Timing

- Latency: request sampled in IDLE at edge 0 gives SETUP in cycle 1, ACCESS in cycles 2..1+ACCESS_CYCLES, and ack in cycle 2+ACCESS_CYCLES. With the default this is cycle 4.
- Transfer period with continuous requests is ACCESS_CYCLES+3 cycles (default 5), including the IDLE cycle.
- Reset values:
  - state = IDLE
  - all sels, o_wr_req and o_busy = 0
  - o_slave_addr, o_data_wr, o_m0_rdata and o_m1_rdata = 0
  - both acks = 0
  - last-granted = master 1, so master 0 wins the first contention
- Reset mid-transfer: outputs clear immediately and asynchronously. The in-flight transfer is abandoned with no ack. A write strobe already issued is not undone.
- Simultaneous requests in IDLE: round-robin only. A single requester is granted regardless of last-granted, so the same master may win back-to-back when uncontested.
- ACCESS_CYCLES = 1: the strobe cycle and the capture cycle coincide.

## Test plan

- **Reset:** assert i_reset_n = 0 mid-ACCESS -> all outputs 0 in the same cycle, no ack; after release, state is IDLE and o_busy = 0.
- **Write via master 0:** m0 write, addr 7'h45, wdata 8'hA5 -> sel2 high for cycles 1..3, o_slave_addr = 5'h05, o_data_wr = 8'hA5, o_wr_req high only in cycle 2, o_m0_ack high only in cycle 4.
- **Read via master 1:** m1 read, addr 7'h7F, i_slave3_rdata = 8'h3C -> sel3 active, o_wr_req never high, o_m1_rdata = 8'h3C with o_m1_ack in cycle 4, o_m0_rdata unchanged.
- **Contention after reset:** m0 and m1 request together -> m0 acked at cycle 4, m1 acked at cycle 9 (default), with no overlap of selects.
- **Continuous contention:** m0 and m1 request for 4 transfers each -> grants alternate m0, m1, m0, m1, ...; m1 alone requesting three times -> three consecutive m1 grants.
- **Parameter sweep:** ACCESS_CYCLES = 1 and 15 -> ack at cycles 3 and 17 respectively; o_wr_req is exactly one cycle in both.
